sw_prio_encoder: RTL and testbench

Synchronised, debounced 8-to-3 priority encoder for the board switch bank. It is the inverse of the existing select-driven LED multiplexer. That block turns a binary select into one chosen data bit; this block turns a one-hot/multi-hot switch vector into a binary index. The index is shown on LEDs and on one active-low seven-segment digit. It sits between the raw board switch inputs and the display outputs in the top-level board wrapper.

---
 rtl/sw_prio_encoder.sv | 160 ++++++++++++++++
 tb/tb_sw_prio_encoder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_prio_encoder.sv
// Synchronised 8-to-3 priority encoder for the switch bank, driving LEDs and one active-low 7-segment digit.
// Build option SW_DEBOUNCE_EN inserts a DEBOUNCE_CYCLES debouncer; undefined, synchronised switches are accepted every cycle.
module sw_prio_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw,
    output logic [2:0]  idx,
    output logic        valid,
    output logic        changed,
    output logic [7:0]  seg0_n,
    output logic [15:0] ledr
);

    // Returns {valid, idx}; bit 7 has the highest priority.
    function automatic logic [3:0] prio_enc(input logic [7:0] pat);
        logic [3:0] res;
        casez (pat)
            8'b1???_????: res = 4'b1_111;
            8'b01??_????: res = 4'b1_110;
            8'b001?_????: res = 4'b1_101;
            8'b0001_????: res = 4'b1_100;
            8'b0000_1???: res = 4'b1_011;
            8'b0000_01??: res = 4'b1_010;
            8'b0000_001?: res = 4'b1_001;
            8'b0000_0001: res = 4'b1_000;
            default:      res = 4'b0_000;
        endcase
        return res;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [2:0] digit, input logic on);
        logic [7:0] seg;
        if (!on) begin
            seg = 8'hFF;
        end else begin
            case (digit)
                3'd0:    seg = 8'hC0;
                3'd1:    seg = 8'hF9;
                3'd2:    seg = 8'hA4;
                3'd3:    seg = 8'hB0;
                3'd4:    seg = 8'h99;
                3'd5:    seg = 8'h92;
                3'd6:    seg = 8'h82;
                3'd7:    seg = 8'hF8;
                default: seg = 8'hFF;
            endcase
        end
        return seg;
    endfunction

    logic [7:0] sw_meta_q;
    logic [7:0] sw_sync_q;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= 8'h00;
            sw_sync_q <= 8'h00;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    logic [7:0] acc_q;

`ifdef SW_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [7:0]    cand_q;
    logic [7:0]    cand_d;
    logic [7:0]    acc_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any difference restarts the count; a full stable run promotes the candidate and the count saturates.
    always_comb begin
        cand_d = cand_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        if (sw_sync_q != cand_q) begin
            cand_d = sw_sync_q;
            cnt_d  = {CW{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            acc_d = cand_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q <= 8'h00;
            acc_q  <= 8'h00;
            cnt_q  <= {CW{1'b0}};
        end else begin
            cand_q <= cand_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    // Without the debouncer the synchronised pattern is accepted every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= sw_sync_q;
        end
    end
`endif

    logic [3:0] enc_s;
    logic [2:0] idx_d;
    logic [2:0] idx_q;
    logic       valid_d;
    logic       valid_q;
    logic       changed_d;
    logic       changed_q;
    logic [7:0] seg_d;
    logic [7:0] seg_q;
    logic [7:0] pat_q;

    // Next display state; changed compares against the currently shown {idx, valid} only.
    always_comb begin
        enc_s     = prio_enc(acc_q);
        idx_d     = enc_s[2:0];
        valid_d   = enc_s[3];
        seg_d     = seg_decode(enc_s[2:0], enc_s[3]);
        changed_d = ({idx_d, valid_d} != {idx_q, valid_q});
    end

    // Output registers; reset leaves the digit blank and no pulse pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            seg_q     <= 8'hFF;
            pat_q     <= 8'h00;
        end else begin
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            seg_q     <= seg_d;
            pat_q     <= acc_q;
        end
    end

    assign idx     = idx_q;
    assign valid   = valid_q;
    assign changed = changed_q;
    assign seg0_n  = seg_q;
    assign ledr    = {pat_q, 3'b000, valid_q, 1'b0, idx_q};

endmodule

// File: tb/tb_sw_prio_encoder.sv
// Self-checking bench for sw_prio_encoder: a cycle model pushes expected outputs to a scoreboard queue,
// each scenario task pops and compares them, plus scenario-specific checks on latency and pulses.
module tb_sw_prio_encoder;
    localparam int DEB = 4;
`ifdef SW_DEBOUNCE_EN
    localparam int NEFF = DEB;
`else
    localparam int NEFF = 0;
`endif
    // Step index (first edge sampling the new sw = 1) on which the outputs move.
    localparam int LAT = NEFF + 4;
    localparam int HW  = NEFF + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic [2:0]  idx;
    logic        valid;
    logic        changed;
    logic [7:0]  seg0_n;
    logic [15:0] ledr;

    logic [28:0] obs;
    logic [28:0] exp_q [$];
    logic [28:0] exp_v;
    logic [7:0]  hist [$];
    logic [7:0]  acc_m;
    logic [2:0]  idx_m;
    logic        valid_m;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [7:0]  seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    localparam logic [28:0] RESET_OBS = {3'd0, 1'b0, 1'b0, 8'hFF, 16'h0000};

    sw_prio_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .sw(sw), .idx(idx), .valid(valid),
        .changed(changed), .seg0_n(seg0_n), .ledr(ledr)
    );

    always #5 clk = ~clk;

    assign obs = {idx, valid, changed, seg0_n, ledr};

    // {valid, idx}: scan upward so the highest set bit is the last one written.
    function automatic logic [3:0] ref_enc(input logic [7:0] p);
        logic [3:0] r;
        r = 4'h0;
        for (int b = 0; b < 8; b++) begin
            if (p[b]) r = {1'b1, 3'(b)};
        end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < HW; i++) hist.push_back(8'h00);
        acc_m   = 8'h00;
        idx_m   = 3'd0;
        valid_m = 1'b0;
    endtask

    // Drive one cycle of sw, push the outputs expected after the next edge, then wait past that edge.
    task automatic step(input logic [7:0] v);
        logic [3:0] e;
        logic [7:0] sg;
        logic       ch;
        logic       same;
        sw = v;
        e  = ref_enc(acc_m);
        ch = ({e[2:0], e[3]} != {idx_m, valid_m});
        sg = e[3] ? seg_tab[e[2:0]] : 8'hFF;
        exp_q.push_back({e[2:0], e[3], ch, sg, acc_m, 3'b000, e[3], 1'b0, e[2:0]});
        idx_m   = e[2:0];
        valid_m = e[3];
        hist.push_back(v);
        void'(hist.pop_front());
        // A pattern is accepted once NEFF+1 consecutive samples agree (two edges of sync delay).
        same = 1'b1;
        for (int i = 1; i <= NEFF; i++) begin
            if (hist[i] != hist[0]) same = 1'b0;
        end
        if (same) acc_m = hist[0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #3;
        n_cmp++;
        if (obs !== RESET_OBS) begin
            n_bad++;
            $display("FAIL reset_hold: got %h want %h", obs, RESET_OBS);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            step(8'h00);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset_release[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
        for (int i = 1; i <= LAT; i++) begin
            step(8'h01);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset_fill[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== RESET_OBS) begin
            n_bad++;
            $display("FAIL reset_async: got %h want %h", obs, RESET_OBS);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= LAT + 1; i++) begin
            step(8'h00);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v || changed !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_no_pulse[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_clean();
        logic [7:0]  pats [4] = '{8'h01, 8'h84, 8'h26, 8'h40};
        logic [2:0]  idxs [4] = '{3'd0, 3'd7, 3'd5, 3'd6};
        logic [7:0]  segs [4] = '{8'hC0, 8'hF8, 8'h92, 8'h82};
        for (int k = 0; k < 4; k++) begin
            for (int c = 1; c <= LAT + 1; c++) begin
                step(pats[k]);
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL clean[%0d.%0d]: got %h want %h", k, c, obs, exp_v);
                end
                if (c == LAT - 1) begin
                    n_cmp++;
                    if (changed !== 1'b0) begin
                        n_bad++;
                        $display("FAIL clean_early[%0d]: changed got %b want 0", k, changed);
                    end
                end
                if (c == LAT) begin
                    n_cmp++;
                    if (changed !== 1'b1 || idx !== idxs[k] || valid !== 1'b1 || seg0_n !== segs[k]
                        || ledr !== {pats[k], 5'b00010, idxs[k]}) begin
                        n_bad++;
                        $display("FAIL clean_latency[%0d]: got idx=%0d v=%b ch=%b seg=%h ledr=%h want idx=%0d seg=%h ledr=%h",
                                 k, idx, valid, changed, seg0_n, ledr, idxs[k], segs[k], {pats[k], 5'b00010, idxs[k]});
                    end
                end
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            step(((i / 2) % 2 == 0) ? 8'h08 : 8'h00);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL bounce[%0d]: got %h want %h", i, obs, exp_v);
            end
`ifdef SW_DEBOUNCE_EN
            n_cmp++;
            if (idx !== 3'd6 || changed !== 1'b0) begin
                n_bad++;
                $display("FAIL bounce_hold[%0d]: got idx=%0d ch=%b want idx=6 ch=0", i, idx, changed);
            end
`endif
        end
        for (int j = 1; j <= LAT + 1; j++) begin
            step(8'h08);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL bounce_settle[%0d]: got %h want %h", j, obs, exp_v);
            end
            if (j == LAT) begin
                n_cmp++;
                if (idx !== 3'd3 || seg0_n !== 8'hB0 || changed !== 1'b1) begin
                    n_bad++;
                    $display("FAIL bounce_latency: got idx=%0d seg=%h ch=%b want idx=3 seg=b0 ch=1", idx, seg0_n, changed);
                end
            end
        end
    endtask

    task automatic test_same_prio();
        int pulses;
        for (int j = 1; j <= LAT + 1; j++) begin
            step(8'h10);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL same_prio_a[%0d]: got %h want %h", j, obs, exp_v);
            end
        end
        pulses = 0;
        for (int j = 1; j <= LAT + 1; j++) begin
            step(8'h13);
            exp_v = exp_q.pop_front();
            if (changed === 1'b1) pulses++;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL same_prio_b[%0d]: got %h want %h", j, obs, exp_v);
            end
        end
        n_cmp++;
        if (pulses != 0 || ledr[15:8] !== 8'h13 || idx !== 3'd4) begin
            n_bad++;
            $display("FAIL same_prio_keep: got pulses=%0d pat=%h idx=%0d want 0/13/4", pulses, ledr[15:8], idx);
        end
        pulses = 0;
        for (int j = 1; j <= LAT + 1; j++) begin
            step(8'h00);
            exp_v = exp_q.pop_front();
            if (changed === 1'b1) pulses++;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL same_prio_clear[%0d]: got %h want %h", j, obs, exp_v);
            end
        end
        n_cmp++;
        if (pulses != 1 || valid !== 1'b0 || seg0_n !== 8'hFF) begin
            n_bad++;
            $display("FAIL same_prio_zero: got pulses=%0d v=%b seg=%h want 1/0/ff", pulses, valid, seg0_n);
        end
    endtask

    task automatic test_reset_midcount();
        for (int j = 1; j <= 3; j++) begin
            step(8'h20);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL midcount_pre[%0d]: got %h want %h", j, obs, exp_v);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== RESET_OBS) begin
            n_bad++;
            $display("FAIL midcount_reset: got %h want %h", obs, RESET_OBS);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int j = 1; j <= LAT + 1; j++) begin
            step(8'h20);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL midcount_post[%0d]: got %h want %h", j, obs, exp_v);
            end
            if (j == LAT - 1 || j == 1) begin
                n_cmp++;
                if (valid !== 1'b0 || changed !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midcount_early[%0d]: got v=%b ch=%b want 0/0", j, valid, changed);
                end
            end
            if (j == LAT) begin
                n_cmp++;
                if (idx !== 3'd5 || valid !== 1'b1 || changed !== 1'b1) begin
                    n_bad++;
                    $display("FAIL midcount_accept: got idx=%0d v=%b ch=%b want 5/1/1", idx, valid, changed);
                end
            end
        end
    endtask

    task automatic test_toggle();
        int pulses;
        int want;
        pulses = 0;
        want   = (NEFF == 0) ? 8 : 0;
        for (int i = 0; i < 35; i++) begin
            step((i >= 32) ? 8'h00 : (((i / 4) % 2 == 0) ? 8'h02 : 8'h00));
            exp_v = exp_q.pop_front();
            if (changed === 1'b1) pulses++;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL toggle[%0d]: got %h want %h", i, obs, exp_v);
            end
            if (i == 3) begin
                n_cmp++;
                if (idx !== ((NEFF == 0) ? 3'd1 : 3'd5)) begin
                    n_bad++;
                    $display("FAIL toggle_first: got idx=%0d want %0d", idx, (NEFF == 0) ? 1 : 5);
                end
            end
        end
        n_cmp++;
        if (pulses != want) begin
            n_bad++;
            $display("FAIL toggle_pulses: got %0d want %0d", pulses, want);
        end
    endtask

    initial begin
        rst = 1'b1;
        sw  = 8'h00;
        model_reset();
        test_reset();
        test_clean();
        test_bounce();
        test_same_prio();
        test_reset_midcount();
        test_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at 200000, expected to have finished");
        $fatal(1);
    end

endmodule
